// File: rtl/dcache_ctrl_pkg.sv
// Shared definitions for the direct-mapped write-back data cache: address field
// layout, line geometry and controller state encoding.
package dcache_ctrl_pkg;

  localparam int unsigned Lines    = 16;
  localparam int unsigned IdxW     = 4;
  localparam int unsigned OffsetW  = 5;
  localparam int unsigned TagW     = 32 - IdxW - OffsetW;
  localparam int unsigned LineW    = 256;
  localparam int unsigned WordW    = 32;
  localparam int unsigned WordSelW = 3;

  localparam int unsigned WordLsb = 2;
  localparam int unsigned IdxLsb  = OffsetW;
  localparam int unsigned TagLsb  = OffsetW + IdxW;

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StWb    = 2'd1;
  localparam logic [1:0] StFetch = 2'd2;
  localparam logic [1:0] StDone  = 2'd3;

  function automatic logic [31:0] line_addr(input logic [TagW-1:0] tag,
                                            input logic [IdxW-1:0] idx);
    return {tag, idx, {OffsetW{1'b0}}};
  endfunction

endpackage

// File: rtl/dcache_array.sv
// Cache storage: valid/dirty bits (reset), tag and data arrays (not reset).
// Combinational read by index; synchronous word merge or full-line fill.
module dcache_array
  import dcache_ctrl_pkg::*;
(
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [IdxW-1:0]     idx_i,
  output logic                valid_o,
  output logic                dirty_o,
  output logic [TagW-1:0]     tag_o,
  output logic [LineW-1:0]    line_o,
  input  logic                word_we_i,
  input  logic [WordSelW-1:0] word_sel_i,
  input  logic [WordW-1:0]    word_data_i,
  input  logic                fill_we_i,
  input  logic [TagW-1:0]     fill_tag_i,
  input  logic [LineW-1:0]    fill_data_i
);

  logic [Lines-1:0] valid_q;
  logic [Lines-1:0] dirty_q;
  logic [TagW-1:0]  tag_q  [Lines];
  logic [LineW-1:0] data_q [Lines];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (fill_we_i) begin
      valid_q[idx_i] <= 1'b1;
      dirty_q[idx_i] <= 1'b0;
    end else if (word_we_i) begin
      dirty_q[idx_i] <= 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (fill_we_i) begin
      tag_q[idx_i]  <= fill_tag_i;
      data_q[idx_i] <= fill_data_i;
    end else if (word_we_i) begin
      data_q[idx_i][{word_sel_i, 5'b0} +: WordW] <= word_data_i;
    end
  end

  assign valid_o = valid_q[idx_i];
  assign dirty_o = dirty_q[idx_i];
  assign tag_o   = tag_q[idx_i];
  assign line_o  = data_q[idx_i];

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back, write-allocate data-cache controller: zero-stall hits,
// miss handling via optional victim write-back followed by a line refill.
module dcache_ctrl
  import dcache_ctrl_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             cpu_req_i,
  input  logic             cpu_we_i,
  input  logic [31:0]      cpu_addr_i,
  input  logic [31:0]      cpu_data_i,
  output logic [31:0]      cpu_data_o,
  output logic             cpu_stall_o,
  output logic             mem_enable_o,
  output logic             mem_write_o,
  output logic [31:0]      mem_addr_o,
  output logic [LineW-1:0] mem_data_o,
  input  logic [LineW-1:0] mem_data_i,
  input  logic             mem_ack_i
);

  logic [1:0]          state_q, state_d;
  logic [TagW-1:0]     req_tag;
  logic [IdxW-1:0]     req_idx;
  logic [WordSelW-1:0] req_word;
  logic                line_valid, line_dirty, hit;
  logic [TagW-1:0]     line_tag;
  logic [LineW-1:0]    line_data;
  logic                word_we, fill_we;
  logic                unused_addr;

  assign req_tag     = cpu_addr_i[TagLsb +: TagW];
  assign req_idx     = cpu_addr_i[IdxLsb +: IdxW];
  assign req_word    = cpu_addr_i[WordLsb +: WordSelW];
  assign unused_addr = ^cpu_addr_i[1:0];

  assign hit = cpu_req_i & line_valid & (line_tag == req_tag);

  // Reset wins over any write in the same cycle so an aborted refill leaves no trace.
  assign word_we = (state_q == StIdle) & hit & cpu_we_i & ~rst_i;
  assign fill_we = (state_q == StFetch) & mem_ack_i & ~rst_i;

  dcache_array u_array (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .idx_i       (req_idx),
    .valid_o     (line_valid),
    .dirty_o     (line_dirty),
    .tag_o       (line_tag),
    .line_o      (line_data),
    .word_we_i   (word_we),
    .word_sel_i  (req_word),
    .word_data_i (cpu_data_i),
    .fill_we_i   (fill_we),
    .fill_tag_i  (req_tag),
    .fill_data_i (mem_data_i)
  );

  assign cpu_data_o = line_data[{req_word, 5'b0} +: WordW];

  always_comb begin
    state_d      = state_q;
    cpu_stall_o  = 1'b0;
    mem_enable_o = 1'b0;
    mem_write_o  = 1'b0;
    mem_addr_o   = '0;
    mem_data_o   = '0;
    case (state_q)
      StIdle: begin
        if (cpu_req_i && !hit) begin
          cpu_stall_o = 1'b1;
          state_d     = (line_valid && line_dirty) ? StWb : StFetch;
        end
      end
      StWb: begin
        cpu_stall_o  = 1'b1;
        mem_enable_o = 1'b1;
        mem_write_o  = 1'b1;
        mem_addr_o   = line_addr(line_tag, req_idx);
        mem_data_o   = line_data;
        if (mem_ack_i) state_d = StFetch;
      end
      StFetch: begin
        cpu_stall_o  = 1'b1;
        mem_enable_o = 1'b1;
        mem_addr_o   = line_addr(req_tag, req_idx);
        if (mem_ack_i) state_d = StDone;
      end
      StDone: begin
        cpu_stall_o = 1'b1;
        state_d     = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= StIdle;
    else       state_q <= state_d;
  end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Self-checking bench for dcache_ctrl: architectural memory model plus a
// line-residency model predict hits, memory traffic and load data.
module tb_dcache_ctrl;

  logic         clk = 1'b0;
  logic         rst, cpu_req, cpu_we, stall, mem_en, mem_wr, mem_ack;
  logic [31:0]  cpu_addr, cpu_wdata, cpu_rdata, mem_addr;
  logic [255:0] mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  dcache_ctrl dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .cpu_req_i    (cpu_req),
    .cpu_we_i     (cpu_we),
    .cpu_addr_i   (cpu_addr),
    .cpu_data_i   (cpu_wdata),
    .cpu_data_o   (cpu_rdata),
    .cpu_stall_o  (stall),
    .mem_enable_o (mem_en),
    .mem_write_o  (mem_wr),
    .mem_addr_o   (mem_addr),
    .mem_data_o   (mem_wdata),
    .mem_data_i   (mem_rdata),
    .mem_ack_i    (mem_ack)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Backing memory and architectural (program-visible) memory overrides.
  logic [31:0] mem_w   [logic [29:0]];
  logic [31:0] arch_ov [logic [29:0]];

  function automatic logic [31:0] mem_rd(input logic [29:0] wa);
    if (mem_w.exists(wa)) return mem_w[wa];
    return {wa, 2'b00} ^ 32'h5A5A_0000;
  endfunction

  function automatic logic [31:0] arch_rd(input logic [29:0] wa);
    if (arch_ov.exists(wa)) return arch_ov[wa];
    return mem_rd(wa);
  endfunction

  // Which memory line each cache slot holds, and whether it differs from memory.
  bit          mv [16];
  bit          md [16];
  logic [22:0] mt [16];

  logic [32:0]  txq[$];
  logic [255:0] last_wb;
  logic [31:0]  last_rd;
  int           ack_delay = 0;
  bit           stray = 1'b0;

  // Memory responder: acks after ack_delay waiting cycles, logs every transfer.
  initial begin
    int          cnt;
    logic [31:0] hold;
    cnt       = 0;
    hold      = '0;
    mem_ack   = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clk);
      #2;
      mem_ack = 1'b0;
      if (rst) begin
        cnt = 0;
      end else if (mem_en) begin
        if (cnt == 0) hold = mem_addr;
        else check("mem_addr_stable", mem_addr, hold);
        if (cnt == ack_delay) begin
          cnt = 0;
          mem_ack = 1'b1;
          check("mem_addr_align", mem_addr[4:0], 0);
          txq.push_back({mem_wr, mem_addr});
          if (mem_wr) begin
            last_wb = mem_wdata;
            for (int w = 0; w < 8; w++) begin
              check("wb_data", mem_wdata[w*32 +: 32], arch_rd({mem_addr[31:5], w[2:0]}));
              mem_w[{mem_addr[31:5], w[2:0]}] = mem_wdata[w*32 +: 32];
            end
          end else begin
            for (int w = 0; w < 8; w++) mem_rdata[w*32 +: 32] = mem_rd({mem_addr[31:5], w[2:0]});
          end
        end else begin
          cnt++;
        end
      end else begin
        cnt     = 0;
        mem_ack = stray;
        if (stray) mem_rdata = {8{32'hBAD0_BAD0}};
      end
    end
  end

  // Any released load must return the architectural value of its word.
  always @(negedge clk) begin
    if (!rst && cpu_req && !cpu_we && !stall)
      check("load_data", cpu_rdata, arch_rd(cpu_addr[31:2]));
  end

  task automatic access(input bit we, input logic [31:0] addr, input logic [31:0] data,
                        output int sc);
    logic [3:0]  idx;
    logic [22:0] tag;
    bit          miss, wb;
    int          guard;
    idx  = addr[8:5];
    tag  = addr[31:9];
    miss = !(mv[idx] && mt[idx] == tag);
    wb   = miss && md[idx];
    txq.delete();
    cpu_req   = 1'b1;
    cpu_we    = we;
    cpu_addr  = addr;
    cpu_wdata = data;
    sc        = 0;
    @(negedge clk);
    check("stall_on_req", stall, miss);
    guard = 0;
    while (stall && guard < 200) begin
      sc++;
      guard++;
      @(negedge clk);
    end
    check("released", stall, 0);
    last_rd = cpu_rdata;
    if (miss) begin
      check("txn_count", txq.size(), wb ? 2 : 1);
      if (txq.size() == (wb ? 2 : 1)) begin
        if (wb) check("wb_addr", txq[0], {1'b1, mt[idx], idx, 5'b0});
        check("fetch_addr", txq[txq.size()-1], {1'b0, tag, idx, 5'b0});
      end
    end else begin
      check("no_txn_on_hit", txq.size(), 0);
    end
    if (we) arch_ov[addr[31:2]] = data;
    mv[idx] = 1'b1;
    mt[idx] = tag;
    md[idx] = (miss ? 1'b0 : md[idx]) | we;
    @(posedge clk);
    #1;
    cpu_req = 1'b0;
    cpu_we  = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int sc;
    int guard;
    rst = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    mem_w[30'h104 >> 2] = 32'hDEAD_BEEF;
    mem_w[30'h304 >> 2] = 32'h3333_0304;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_stall", stall, 0);
    check("rst_mem_en", mem_en, 0);
    check("rst_mem_wr", mem_wr, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_data", |mem_wdata, 0);
    @(posedge clk);
    #1;

    // 1: cold load
    access(0, 32'h0000_0104, 0, sc);
    check("t1_stall_cycles", sc, 3);
    check("t1_fetch", txq.size() > 0 ? txq[0] : 33'h0, {1'b0, 32'h0000_0100});
    check("t1_data", last_rd, 32'hDEAD_BEEF);

    // 2: store hit, then load it back
    access(1, 32'h0000_0104, 32'h1234_5678, sc);
    check("t2_store_stall", sc, 0);
    access(0, 32'h0000_0104, 0, sc);
    check("t2_data", last_rd, 32'h1234_5678);

    // 3: conflict miss on a dirty line
    access(0, 32'h0000_0304, 0, sc);
    check("t3_stall_cycles", sc, 4);
    check("t3_wb", txq.size() > 0 ? txq[0] : 33'h0, {1'b1, 32'h0000_0100});
    check("t3_wb_word1", last_wb[63:32], 32'h1234_5678);
    check("t3_data", last_rd, 32'h3333_0304);

    // 4: slow memory
    ack_delay = 10;
    access(0, 32'h0000_1040, 0, sc);
    check("t4_stall_cycles", sc, 13);
    ack_delay = 0;

    // store miss allocates the line
    access(1, 32'h0000_2008, 32'hCAFE_F00D, sc);
    check("sm_stall_cycles", sc, 3);
    access(0, 32'h0000_2008, 0, sc);
    check("sm_data", last_rd, 32'hCAFE_F00D);

    // 5: reset during write-back drops the dirty data
    access(1, 32'h0000_0304, 32'h55AA_55AA, sc);
    ack_delay = 3;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0000_0104;
    guard = 0;
    @(negedge clk);
    while (!(mem_en && mem_wr) && guard < 20) begin
      guard++;
      @(negedge clk);
    end
    check("t5_in_wb", mem_en & mem_wr, 1);
    @(posedge clk);
    #1 rst = 1'b1; cpu_req = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("t5_stall", stall, 0);
    check("t5_mem_en", mem_en, 0);
    for (int i = 0; i < 16; i++) begin
      mv[i] = 1'b0;
      md[i] = 1'b0;
    end
    arch_ov.delete();
    ack_delay = 0;
    @(posedge clk);
    #1;
    access(0, 32'h0000_0104, 0, sc);
    check("t5_reload_cycles", sc, 3);
    check("t5_reload_data", last_rd, 32'h1234_5678);
    access(0, 32'h0000_0304, 0, sc);
    check("t5_dropped_data", last_rd, 32'h3333_0304);
    access(0, 32'h0000_0104, 0, sc);

    // 6: stray acks alongside hit traffic
    stray = 1'b1;
    access(0, 32'h0000_0104, 0, sc);
    access(0, 32'h0000_0108, 0, sc);
    access(1, 32'h0000_010C, 32'h7777_8888, sc);
    access(0, 32'h0000_010C, 0, sc);
    check("t6_store_data", last_rd, 32'h7777_8888);
    stray = 1'b0;
    access(0, 32'h0000_0104, 0, sc);
    check("t6_intact", last_rd, 32'h1234_5678);
    check("t6_no_stall", sc, 0);

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
